cpu_sequencer: RTL and testbench

Multi-cycle control state machine for the RV32I core. Fetches an instruction word over a req/ack memory port into an instruction register, presents it to the decoder, and steps the datapath through execute, memory and writeback. Owns the PC and the instruction register, issues register-file write enables, and raises traps on illegal instructions, ECALL/EBREAK and misaligned control-flow targets.

---
 rtl/cpu_sequencer_if.sv | 24 ++
 rtl/cpu_sequencer.sv | 159 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Memory request/acknowledge port shared by the sequencer (master) and the memory (slave).
interface cpu_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback, trap.
// Define CPU_SEQ_INSTRET_EN to build the retired-instruction counter; otherwise instret is 0.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    cpu_sequencer_if.master        bus,
    output logic [31:0]            ir_q,
    input  logic [4:0]             opcode,
    input  logic [2:0]             func3,
    input  logic                   invalid,
    input  logic                   branch_taken,
    input  logic [31:0]            target,
    output logic [31:0]            pc_q,
    output logic                   rf_we,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic [31:0]            instret
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        req;
    logic        we;
    logic        addr_sel;
    logic        ir_load;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        cause_load;
    logic [1:0]  cause_d;
    logic        take_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            trap_cause <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load)
                ir_q <= bus.mem_rdata;
            if (pc_load)
                pc_q <= pc_next;
            if (cause_load)
                trap_cause <= cause_d;
        end
    end

    assign take_target = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                         ((opcode == OP_BRANCH) && branch_taken);

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        we         = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_next    = pc_q;
        cause_load = 1'b0;
        cause_d    = '0;
        rf_we      = 1'b0;

        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (bus.mem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (invalid) begin
                    cause_load = 1'b1;
                    cause_d    = 2'd1;
                    state_d    = TRAP;
                end else if ((opcode == OP_SYSTEM) && (func3 == 3'b000)) begin
                    cause_load = 1'b1;
                    cause_d    = ir_q[20] ? 2'd2 : 2'd3;
                    state_d    = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if ((opcode == OP_LOAD) || (opcode == OP_STORE))
                    state_d = MEM;
                else
                    state_d = WB;
            end
            MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = (opcode == OP_STORE);
                if (bus.mem_ack)
                    state_d = WB;
            end
            WB: begin
                // A misaligned control-flow target aborts retirement: no write, PC held.
                if (take_target && (target[1:0] != 2'b00)) begin
                    cause_load = 1'b1;
                    cause_d    = 2'd0;
                    state_d    = TRAP;
                end else begin
                    rf_we   = (opcode != OP_STORE) && (opcode != OP_BRANCH);
                    pc_load = 1'b1;
                    pc_next = take_target ? target : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Gating with rst drops the request combinationally while reset is held.
    assign bus.mem_req      = req & ~rst;
    assign bus.mem_we       = we & ~rst;
    assign bus.mem_addr_sel = addr_sel & ~rst;
    assign trap             = (state_q == TRAP);

`ifdef CPU_SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret_q <= '0;
        else if ((state_q == WB) && (state_d == FETCH))
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a stub decoder and a wait-state memory model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir_q;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        invalid;
    logic        branch_taken = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc_q;
    logic        rf_we;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [31:0] rdata = 32'h0;
    logic        ack_always = 1'b0;
    int unsigned ack_delay = 0;
    int unsigned wait_cnt = 0;
    int          checks = 0;
    int          fails = 0;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] LOAD  = 32'h0000_A103;
    localparam logic [31:0] STORE = 32'h00A0_2023;
    localparam logic [31:0] BEQ   = 32'h0000_0463;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] CSRRS = 32'h0010_2073;

    always #5 clk = ~clk;

    cpu_sequencer_if bus();

    assign opcode        = ir_q[6:2];
    assign func3         = ir_q[14:12];
    assign invalid       = (ir_q[1:0] != 2'b11);
    assign bus.mem_rdata = rdata;
    assign bus.mem_ack   = ack_always | (bus.mem_req && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    cpu_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ir_q         (ir_q),
        .opcode       (opcode),
        .func3        (func3),
        .invalid      (invalid),
        .branch_taken (branch_taken),
        .target       (target),
        .pc_q         (pc_q),
        .rf_we        (rf_we),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    function automatic logic [31:0] exp_instret(input int unsigned n);
`ifdef CPU_SEQ_INSTRET_EN
        return n;
`else
        return 32'h0;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        ack_always = 1'b0;
        ack_delay  = 0;
        rdata      = ADDI;
        rst        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we, trap, trap_cause} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we, trap, trap_cause});
        end
        checks++;
        if (pc_q !== 32'h100 || ir_q !== 32'h0 || instret !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: pc=%h ir=%h instret=%h expected 100/0/0", pc_q, ir_q, instret);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel} !== 3'b100) begin
            fails++;
            $display("FAIL reset_fetch: got %b expected 100", {bus.mem_req, bus.mem_we, bus.mem_addr_sel});
        end
    endtask

    task automatic test_alu;
        ack_always = 1'b1;
        ack_delay  = 0;
        rdata      = ADDI;
        do_reset();
        step(1);
        checks++;
        if (ir_q !== ADDI || bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL alu_decode: ir=%h req=%b expected %h/0", ir_q, bus.mem_req, ADDI);
        end
        step(2);
        checks++;
        if (rf_we !== 1'b1 || pc_q !== 32'h100) begin
            fails++;
            $display("FAIL alu_wb: rf_we=%b pc=%h expected 1/00000100", rf_we, pc_q);
        end
        step(1);
        checks++;
        if (rf_we !== 1'b0 || pc_q !== 32'h104 || bus.mem_req !== 1'b1 || instret !== exp_instret(1)) begin
            fails++;
            $display("FAIL alu_retire: rf_we=%b pc=%h req=%b instret=%h expected 0/00000104/1/%h",
                     rf_we, pc_q, bus.mem_req, instret, exp_instret(1));
        end
        ack_always = 1'b0;
    endtask

    task automatic test_load_store;
        // {mem_req, mem_we, mem_addr_sel, rf_we} per cycle, two wait states on each access
        logic [3:0] exp_ld [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                                    4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b1000};
        logic [3:0] exp_st [6]  = '{4'b1000, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b1000};
        ack_delay = 2;
        rdata     = LOAD;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step(1);
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we} !== exp_ld[c]) begin
                fails++;
                $display("FAIL load_cycle%0d: got %b expected %b", c + 1,
                         {bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we}, exp_ld[c]);
            end
        end
        checks++;
        if (pc_q !== 32'h104) begin
            fails++;
            $display("FAIL load_pc: got %h expected 00000104", pc_q);
        end
        ack_delay = 0;
        rdata     = STORE;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step(1);
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we} !== exp_st[c]) begin
                fails++;
                $display("FAIL store_cycle%0d: got %b expected %b", c + 1,
                         {bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we}, exp_st[c]);
            end
        end
        checks++;
        if (pc_q !== 32'h104) begin
            fails++;
            $display("FAIL store_pc: got %h expected 00000104", pc_q);
        end
    endtask

    task automatic test_branch;
        ack_delay    = 0;
        rdata        = BEQ;
        branch_taken = 1'b1;
        target       = 32'h108;
        do_reset();
        step(3);
        checks++;
        if (rf_we !== 1'b0 || trap !== 1'b0) begin
            fails++;
            $display("FAIL branch_wb: rf_we=%b trap=%b expected 0/0", rf_we, trap);
        end
        step(1);
        checks++;
        if (pc_q !== 32'h108) begin
            fails++;
            $display("FAIL branch_taken_pc: got %h expected 00000108", pc_q);
        end
        branch_taken = 1'b0;
        do_reset();
        step(4);
        checks++;
        if (pc_q !== 32'h104 || trap !== 1'b0) begin
            fails++;
            $display("FAIL branch_not_taken: pc=%h trap=%b expected 00000104/0", pc_q, trap);
        end
        branch_taken = 1'b1;
        target       = 32'h10A;
        do_reset();
        step(3);
        checks++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL misalign_wb: rf_we=%b expected 0", rf_we);
        end
        step(1);
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'd0 || pc_q !== 32'h100 || bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL misalign_trap: trap=%b cause=%0d pc=%h req=%b expected 1/0/00000100/0",
                     trap, trap_cause, pc_q, bus.mem_req);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_traps;
        logic [31:0] words  [3] = '{32'h0000_0000, 32'h0010_0073, 32'h0000_0073};
        logic [1:0]  causes [3] = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            ack_always = 1'b0;
            rdata      = words[i];
            do_reset();
            step(1);
            checks++;
            if (trap !== 1'b0) begin
                fails++;
                $display("FAIL trap%0d_decode: trap=%b expected 0", i, trap);
            end
            step(1);
            checks++;
            if (trap !== 1'b1 || trap_cause !== causes[i]) begin
                fails++;
                $display("FAIL trap%0d_cause: trap=%b cause=%0d expected 1/%0d", i, trap, trap_cause, causes[i]);
            end
            ack_always = 1'b1;
            step(5);
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we, trap} !== 5'b00001 ||
                pc_q !== 32'h100 || trap_cause !== causes[i]) begin
                fails++;
                $display("FAIL trap%0d_halt: ctrl=%b pc=%h cause=%0d expected 00001/00000100/%0d",
                         i, {bus.mem_req, bus.mem_we, bus.mem_addr_sel, rf_we, trap}, pc_q, trap_cause, causes[i]);
            end
        end
        ack_always = 1'b0;
    endtask

    task automatic test_csr;
        rdata = CSRRS;
        do_reset();
        step(3);
        checks++;
        if (rf_we !== 1'b1 || trap !== 1'b0) begin
            fails++;
            $display("FAIL csr_wb: rf_we=%b trap=%b expected 1/0", rf_we, trap);
        end
        step(1);
        checks++;
        if (pc_q !== 32'h104) begin
            fails++;
            $display("FAIL csr_pc: got %h expected 00000104", pc_q);
        end
    endtask

    task automatic test_reset_mid_mem;
        ack_delay = 0;
        rdata     = ADDI;
        do_reset();
        step(4);
        rdata     = LOAD;
        ack_delay = 3;
        step(6);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b1 || pc_q !== 32'h104) begin
            fails++;
            $display("FAIL midmem_pre: req=%b sel=%b pc=%h expected 1/1/00000104",
                     bus.mem_req, bus.mem_addr_sel, pc_q);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || pc_q !== 32'h100 || ir_q !== 32'h0) begin
            fails++;
            $display("FAIL midmem_rst: req=%b pc=%h ir=%h expected 0/00000100/00000000",
                     bus.mem_req, pc_q, ir_q);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b0 || instret !== 32'h0) begin
            fails++;
            $display("FAIL midmem_restart: req=%b sel=%b instret=%h expected 1/0/0",
                     bus.mem_req, bus.mem_addr_sel, instret);
        end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back;
        rdata  = JAL;
        target = 32'hFFFF_FFFC;
        do_reset();
        step(3);
        checks++;
        if (rf_we !== 1'b1) begin
            fails++;
            $display("FAIL jal_wb: rf_we=%b expected 1", rf_we);
        end
        step(1);
        checks++;
        if (pc_q !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL jal_pc: got %h expected fffffffc", pc_q);
        end
        rdata = ADDI;
        step(4);
        checks++;
        if (pc_q !== 32'h0 || instret !== exp_instret(2)) begin
            fails++;
            $display("FAIL pc_wrap: pc=%h instret=%h expected 00000000/%h", pc_q, instret, exp_instret(2));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_traps();
        test_csr();
        test_reset_mid_mem();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
